apb_slave_mem: RTL and testbench

- APB (AMBA3) completer directly downstream of the APB bridge.
- Consumes the bridge's PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Backed by a small register-array memory, with a programmable number of wait states.
- Flags out-of-range accesses and protocol violations, so the UVM environment has a checkable, non-trivial target.

---
 rtl/apb_slave_mem_if.sv | 26 ++
 rtl/apb_slave_mem.sv | 140 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle: bridge request signals plus completer response.
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  // Bridge side drives the request, samples the response
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // Completer side samples the request, drives the response
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register-array memory with programmable wait
// states, out-of-range error responses and a sticky protocol-violation flag.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                RESET,
  apb_slave_mem_if.slave      apb,
  input  logic                proto_err_clr,
  output logic                proto_err,
  output logic [15:0]         xfer_count
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WS_W  = 4;
  localparam logic [WS_W-1:0]     WS_LAST = WS_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [WS_W-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic                    aerr_q, aerr_d;
  logic                    proto_q, proto_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic                    mem_we;
  logic                    proto_set;
  logic                    access_ok;

  // Access phase is legal only if the bridge holds the request stable
  assign access_ok = apb.PSEL && apb.PENABLE &&
                     (apb.PADDR == addr_q) && (apb.PWRITE == wr_q);

  // Next-state, transfer bookkeeping and registered response decode
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    aerr_d    = aerr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    proto_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          addr_d  = apb.PADDR;
          wr_d    = apb.PWRITE;
          aerr_d  = ({1'b0, apb.PADDR} >= DEPTH_A);
          wait_d  = '0;
          state_d = S_ACCESS;
        end else if (apb.PSEL && apb.PENABLE) begin
          proto_set = 1'b1;
        end
      end
      S_ACCESS: begin
        if (access_ok) begin
          if (!pready_q) begin
            wait_d = WS_W'(wait_q + WS_W'(1));
          end else begin
            mem_we  = wr_q && !aerr_q;
            cnt_d   = 16'(cnt_q + 16'd1);
            state_d = S_IDLE;
          end
        end else begin
          proto_set = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new violation wins over a clear in the same cycle
    proto_d   = proto_set || (proto_q && !proto_err_clr);

    // Response lines are computed one cycle ahead so they leave flops
    pready_d  = (state_d == S_ACCESS) && (wait_d == WS_LAST);
    pslverr_d = pready_d && aerr_d;
    prdata_d  = (pready_d && !wr_d && !aerr_d) ? mem_q[addr_d[IDX_W-1:0]]
                                               : '0;
  end

  // Control and response registers
  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      aerr_q    <= 1'b0;
      proto_q   <= 1'b0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      aerr_q    <= aerr_d;
      proto_q   <= proto_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage array; write data is taken from the completing access edge
  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q[IDX_W-1:0]] <= apb.PWDATA;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign proto_err   = proto_q;
  assign xfer_count  = cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 3 and 2 wait states.
module tb_apb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic        clr;
  logic [1:0]  sel;

  logic        perr0, perr1, perr2;
  logic [15:0] cnt0, cnt1, cnt2;

  logic [7:0]  o_rdata;
  logic        o_ready;
  logic        o_slverr;
  logic        o_perr;
  logic [15:0] o_cnt;

  int n_checks;
  int n_fail;

  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();
  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if2 ();

  assign if0.PSEL = psel && (sel == 2'd0);
  assign if1.PSEL = psel && (sel == 2'd1);
  assign if2.PSEL = psel && (sel == 2'd2);
  assign if0.PENABLE = penable;
  assign if1.PENABLE = penable;
  assign if2.PENABLE = penable;
  assign if0.PWRITE = pwrite;
  assign if1.PWRITE = pwrite;
  assign if2.PWRITE = pwrite;
  assign if0.PADDR = paddr;
  assign if1.PADDR = paddr;
  assign if2.PADDR = paddr;
  assign if0.PWDATA = pwdata;
  assign if1.PWDATA = pwdata;
  assign if2.PWDATA = pwdata;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .RESET(rst_n), .apb(if0),
    .proto_err_clr(clr), .proto_err(perr0), .xfer_count(cnt0));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .RESET(rst_n), .apb(if1),
    .proto_err_clr(clr), .proto_err(perr1), .xfer_count(cnt1));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .PCLK(clk), .RESET(rst_n), .apb(if2),
    .proto_err_clr(clr), .proto_err(perr2), .xfer_count(cnt2));

  // Observe whichever instance is currently selected
  always_comb begin
    o_rdata  = if0.PRDATA;
    o_ready  = if0.PREADY;
    o_slverr = if0.PSLVERR;
    o_perr   = perr0;
    o_cnt    = cnt0;
    case (sel)
      2'd1: begin
        o_rdata = if1.PRDATA; o_ready = if1.PREADY; o_slverr = if1.PSLVERR;
        o_perr  = perr1;      o_cnt   = cnt1;
      end
      2'd2: begin
        o_rdata = if2.PRDATA; o_ready = if2.PREADY; o_slverr = if2.PSLVERR;
        o_perr  = perr2;      o_cnt   = cnt2;
      end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    clr     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One legal transfer; returns at the negedge after the completion edge
  task automatic xfer(input logic [1:0] d, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wd, input int ws, input logic [7:0] exp_rd,
                      input logic exp_err, input string tag);
    sel     = d;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(negedge clk);
    penable = 1'b1;
    for (int i = 0; i < ws; i++) begin
      check({tag, "_wait_ready"}, 16'(o_ready), 16'd0);
      @(negedge clk);
    end
    check({tag, "_ready"},  16'(o_ready),  16'd1);
    check({tag, "_slverr"}, 16'(o_slverr), 16'(exp_err));
    check({tag, "_rdata"},  16'(o_rdata),  16'(exp_rd));
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sel      = 2'd0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    pwdata   = 8'h00;
    clr      = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rdata",  16'(o_rdata),  16'd0);
    check("rst_ready",  16'(o_ready),  16'd0);
    check("rst_slverr", 16'(o_slverr), 16'd0);
    check("rst_perr",   16'(o_perr),   16'd0);
    check("rst_cnt",    o_cnt,         16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero wait states: write then read back
    xfer(2'd0, 1'b1, 8'h03, 8'hA5, 0, 8'h00, 1'b0, "t1_wr");
    xfer(2'd0, 1'b0, 8'h03, 8'h00, 0, 8'hA5, 1'b0, "t1_rd");
    check("t1_ready_after", 16'(o_ready), 16'd0);
    check("t1_cnt", o_cnt, 16'd2);
    idle(1);

    // Three wait states on a fresh location
    xfer(2'd1, 1'b0, 8'h00, 8'h00, 3, 8'h00, 1'b0, "t2_rd");
    check("t2_ready_after", 16'(o_ready), 16'd0);
    check("t2_cnt", o_cnt, 16'd1);
    idle(1);

    // Out-of-range write and read; 0x20 and 0x13 alias onto 0x00 and 0x03
    xfer(2'd0, 1'b1, 8'h20, 8'h5A, 0, 8'h00, 1'b1, "t3_wr_err");
    xfer(2'd0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, "t3_rd0");
    xfer(2'd0, 1'b0, 8'h13, 8'h00, 0, 8'h00, 1'b1, "t3_rd_err");
    check("t3_cnt", o_cnt, 16'd5);

    // Back-to-back transfers with read-after-write
    xfer(2'd0, 1'b1, 8'h01, 8'h11, 0, 8'h00, 1'b0, "t4_wr1");
    xfer(2'd0, 1'b1, 8'h02, 8'h22, 0, 8'h00, 1'b0, "t4_wr2");
    xfer(2'd0, 1'b0, 8'h02, 8'h00, 0, 8'h22, 1'b0, "t4_rd2");
    xfer(2'd0, 1'b0, 8'h01, 8'h00, 0, 8'h11, 1'b0, "t4_rd1");
    check("t4_cnt", o_cnt, 16'd9);
    idle(1);

    // Access phase with no setup phase
    sel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
    @(negedge clk);
    check("t5_noset_perr",  16'(o_perr),  16'd1);
    check("t5_noset_ready", 16'(o_ready), 16'd0);
    idle(1);
    xfer(2'd0, 1'b0, 8'h05, 8'h00, 0, 8'h00, 1'b0, "t5_rd5");
    check("t5_perr_sticky", 16'(o_perr), 16'd1);
    check("t5_cnt_a", o_cnt, 16'd10);
    psel = 1'b0; penable = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_perr_clr", 16'(o_perr), 16'd0);

    // Address changed during the access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h01;
    @(negedge clk);
    check("t5_chg_ready_pre", 16'(o_ready), 16'd1);
    penable = 1'b1; paddr = 8'h02;
    @(negedge clk);
    check("t5_chg_perr",  16'(o_perr),  16'd1);
    check("t5_chg_ready", 16'(o_ready), 16'd0);
    check("t5_chg_cnt",   o_cnt,        16'd10);
    xfer(2'd0, 1'b0, 8'h02, 8'h00, 0, 8'h22, 1'b0, "t5_rd2");
    check("t5_cnt_b", o_cnt, 16'd11);

    // Set beats clear in the same cycle
    psel = 1'b0; penable = 1'b0; clr = 1'b1;
    @(negedge clk);
    check("t5_perr_clr2", 16'(o_perr), 16'd0);
    psel = 1'b1; penable = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("t5_set_over_clr", 16'(o_perr), 16'd1);
    psel = 1'b0; penable = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_perr_clr3", 16'(o_perr), 16'd0);

    // Reset in the completing access cycle of a write (two wait states)
    xfer(2'd2, 1'b1, 8'h06, 8'h33, 2, 8'h00, 1'b0, "t6_wr6");
    check("t6_cnt_a", o_cnt, 16'd1);
    psel = 1'b1; penable = 1'b1;
    @(negedge clk);
    check("t6_perr_set", 16'(o_perr), 16'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    check("t6_w0_ready", 16'(o_ready), 16'd0);
    @(negedge clk);
    check("t6_w1_ready", 16'(o_ready), 16'd0);
    @(negedge clk);
    check("t6_pre_rst_ready", 16'(o_ready), 16'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready",  16'(o_ready),  16'd0);
    check("t6_rst_slverr", 16'(o_slverr), 16'd0);
    check("t6_rst_rdata",  16'(o_rdata),  16'd0);
    check("t6_rst_perr",   16'(o_perr),   16'd0);
    check("t6_rst_cnt",    o_cnt,         16'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(2'd2, 1'b0, 8'h04, 8'h00, 2, 8'h00, 1'b0, "t6_rd4");
    xfer(2'd2, 1'b0, 8'h06, 8'h00, 2, 8'h00, 1'b0, "t6_rd6");
    check("t6_cnt_b", o_cnt, 16'd2);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
